// File: rtl/mod14_disp_pkg.sv
// Shared constants and types for the mod-14 two-digit display scanner.
// Holds the scan state enum, the count limit and the gfedcba segment patterns.
package mod14_disp_pkg;

    localparam logic [3:0] MOD_MAX = 4'd13;

    typedef enum logic {
        S_ONES = 1'b0,
        S_TENS = 1'b1
    } scan_state_e;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit to seven-segment decoder (active-high, seg[0]=a).
// Ports: digit (4b value), blank (force all segments off), seg (7b drive).
// Values 10..15 decode to the "E" pattern.
module seg7_decode
    import mod14_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_E;
        unique case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_E;
        endcase
        if (blank) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/mod14_seg_scanner.sv
// Two-digit multiplexed display stage for the mod-14 counter, with wrap/err flags.
// Ports: clk, rst (sync, active-high), count[3:0] in; seg[6:0], an[1:0], wrap, err out.
// Param SCAN_DIV = cycles per digit. Macro LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module mod14_seg_scanner
    import mod14_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       wrap,
    output logic       err
);

    localparam logic [15:0] PRE_LAST = 16'(SCAN_DIV - 1);

    logic [3:0]  count_q;
    logic        wrap_q;
    logic        err_q;
    logic [15:0] pre_q, pre_d;
    logic        pre_term;
    scan_state_e state_q, state_d;
    logic        bad_q, bad_d;
    logic        tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic        snap_ld;
    logic [3:0]  dig_sel;
    logic        blank_sel;

    assign pre_term = (pre_q == PRE_LAST);
    // Snapshot only at the end of the tens dwell so both digits of a frame agree.
    assign snap_ld  = (state_q == S_TENS) && pre_term;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 4'd0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            pre_q   <= 16'd0;
            state_q <= S_ONES;
            bad_q   <= 1'b0;
            tens_q  <= 1'b0;
            ones_q  <= 4'd0;
        end else begin
            count_q <= count;
            wrap_q  <= (count_q == MOD_MAX) && (count == 4'd0);
            err_q   <= (count_q > MOD_MAX);
            pre_q   <= pre_d;
            state_q <= state_d;
            bad_q   <= bad_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
        end
    end

    always_comb begin
        pre_d   = pre_term ? 16'd0 : pre_q + 16'd1;
        state_d = state_q;
        an      = 2'b01;
        unique case (state_q)
            S_ONES: begin
                an = 2'b01;
                if (pre_term) state_d = S_TENS;
            end
            S_TENS: begin
                an = 2'b10;
                if (pre_term) state_d = S_ONES;
            end
            default: begin
                an      = 2'b01;
                state_d = S_ONES;
            end
        endcase
    end

    always_comb begin
        bad_d  = bad_q;
        tens_d = tens_q;
        ones_d = ones_q;
        if (snap_ld) begin
            bad_d  = (count_q > MOD_MAX);
            tens_d = (count_q >= 4'd10);
            ones_d = (count_q >= 4'd10) ? count_q - 4'd10 : count_q;
        end
    end

    always_comb begin
        dig_sel   = ones_q;
        blank_sel = 1'b0;
        unique case (state_q)
            S_ONES: begin
                dig_sel = bad_q ? 4'hE : ones_q;
            end
            S_TENS: begin
                dig_sel = {3'b000, tens_q};
`ifdef LEADING_ZERO_BLANK_EN
                blank_sel = bad_q | ~tens_q;
`else
                blank_sel = bad_q;
`endif
            end
            default: begin
                dig_sel   = ones_q;
                blank_sel = 1'b0;
            end
        endcase
    end

    seg7_decode u_dec (
        .digit (dig_sel),
        .blank (blank_sel),
        .seg   (seg)
    );

    assign wrap = wrap_q;
    assign err  = err_q;

endmodule

// File: tb/tb_mod14_seg_scanner.sv
// Directed testbench for mod14_seg_scanner (SCAN_DIV=4).
// Table of held counts with expected digit patterns, plus multi-cycle sequences.
module tb_mod14_seg_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] count;
    logic [6:0] seg;
    logic [1:0] an;
    logic       wrap;
    logic       err;

    int total = 0;
    int bad = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] TZ = 7'h00;
`else
    localparam logic [6:0] TZ = 7'h3F;
`endif

    typedef struct {
        logic [3:0] cnt;
        logic [6:0] ones;
        logic [6:0] tens;
    } vec_t;

    vec_t vt[8];

    mod14_seg_scanner #(.SCAN_DIV(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .count (count),
        .seg   (seg),
        .an    (an),
        .wrap  (wrap),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Advance until the cycle right after an S_TENS->S_ONES transition.
    task automatic wait_frame();
        logic [1:0] prev;
        bit         hit;
        hit  = 1'b0;
        prev = an;
        for (int i = 0; i < 20 && !hit; i++) begin
            step(1);
            if (prev == 2'b10 && an == 2'b01) hit = 1'b1;
            prev = an;
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL frame_timeout actual=none expected=boundary");
        end
    endtask

    initial begin
        vt[0] = '{4'd0,  7'h3F, TZ};
        vt[1] = '{4'd5,  7'h6D, TZ};
        vt[2] = '{4'd9,  7'h6F, TZ};
        vt[3] = '{4'd10, 7'h3F, 7'h06};
        vt[4] = '{4'd13, 7'h4F, 7'h06};
        vt[5] = '{4'd14, 7'h79, 7'h00};
        vt[6] = '{4'd15, 7'h79, 7'h00};
        vt[7] = '{4'd7,  7'h07, TZ};

        rst   = 1'b1;
        count = 4'd0;
        step(3);
        chk("rst_an", {30'd0, an}, 32'h1);
        chk("rst_seg", {25'd0, seg}, 32'h3F);
        chk("rst_wrap", {31'd0, wrap}, 32'h0);
        chk("rst_err", {31'd0, err}, 32'h0);
        rst = 1'b0;
        step(3);
        chk("dwell_ones", {30'd0, an}, 32'h1);
        step(1);
        chk("first_toggle", {30'd0, an}, 32'h2);
        step(3);
        chk("dwell_tens", {30'd0, an}, 32'h2);
        step(1);
        chk("second_toggle", {30'd0, an}, 32'h1);

        for (int k = 0; k < 8; k++) begin
            count = vt[k].cnt;
            wait_frame();
            wait_frame();
            chk($sformatf("vec%0d_an1", k), {30'd0, an}, 32'h1);
            chk($sformatf("vec%0d_ones", k), {25'd0, seg}, {25'd0, vt[k].ones});
            step(4);
            chk($sformatf("vec%0d_an2", k), {30'd0, an}, 32'h2);
            chk($sformatf("vec%0d_tens", k), {25'd0, seg}, {25'd0, vt[k].tens});
        end

        // Mid-frame change 7 -> 12 must wait for the next boundary.
        wait_frame();
        step(1);
        count = 4'd12;
        step(2);
        chk("mid_hold_ones", {25'd0, seg}, 32'h07);
        step(1);
        chk("mid_hold_tens", {25'd0, seg}, {25'd0, TZ});
        wait_frame();
        chk("mid_new_ones", {25'd0, seg}, 32'h5B);
        step(4);
        chk("mid_new_tens", {25'd0, seg}, 32'h06);

        // Wrap stepping 12,13,0,1.
        count = 4'd12;
        step(1);
        chk("wrap_a", {31'd0, wrap}, 32'h0);
        count = 4'd13;
        step(1);
        chk("wrap_b", {31'd0, wrap}, 32'h0);
        count = 4'd0;
        step(1);
        chk("wrap_pulse", {31'd0, wrap}, 32'h1);
        count = 4'd1;
        step(1);
        chk("wrap_end", {31'd0, wrap}, 32'h0);
        step(1);
        chk("wrap_quiet", {31'd0, wrap}, 32'h0);

        // Alternating 13/0: pulse only on 13->0.
        for (int i = 0; i < 4; i++) begin
            count = (i % 2 == 0) ? 4'd13 : 4'd0;
            step(1);
            chk($sformatf("alt%0d", i), {31'd0, wrap}, (i % 2 == 0) ? 32'h0 : 32'h1);
        end

        // Out-of-range then recovery.
        count = 4'd15;
        step(1);
        chk("err_e1", {31'd0, err}, 32'h0);
        step(1);
        chk("err_e2", {31'd0, err}, 32'h1);
        wait_frame();
        wait_frame();
        chk("err_ones", {25'd0, seg}, 32'h79);
        chk("err_hold", {31'd0, err}, 32'h1);
        step(4);
        chk("err_tens", {25'd0, seg}, 32'h00);
        count = 4'd3;
        step(1);
        chk("err_f1", {31'd0, err}, 32'h1);
        step(1);
        chk("err_f2", {31'd0, err}, 32'h0);
        wait_frame();
        wait_frame();
        chk("rec_ones", {25'd0, seg}, 32'h4F);
        step(4);
        chk("rec_tens", {25'd0, seg}, {25'd0, TZ});

        // Reset pulse in S_TENS with count=11.
        count = 4'd11;
        wait_frame();
        wait_frame();
        step(5);
        chk("pre_rst_an", {30'd0, an}, 32'h2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mr_an", {30'd0, an}, 32'h1);
        chk("mr_seg", {25'd0, seg}, 32'h3F);
        chk("mr_err", {31'd0, err}, 32'h0);
        step(3);
        chk("mr_dwell", {30'd0, an}, 32'h1);
        step(1);
        chk("mr_toggle", {30'd0, an}, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod14_seg_scanner.md
# mod14_seg_scanner

Display stage that sits directly downstream of the team's mod-14 counter. It samples the 4-bit count (0..13) and converts it to two decimal digits. It drives a time-multiplexed two-digit seven-segment display and flags counter wrap (13→0) and out-of-range input. The display snapshot is updated only at scan-frame boundaries, so a count change never tears across digits.

## Interface
- SCAN_DIV, default 4: clock cycles each digit is enabled; legal range 2..65535.
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset, sampled on rising clk.
- count  in  4  count value from the upstream mod-14 counter; legal 0..13.
- seg  out  7  segment drive, active-high; seg[0]=a … seg[6]=g.
- an  out  2  one-hot digit enable, active-high; an[0]=ones, an[1]=tens.
- wrap  out  1  one-cycle pulse on counter wrap 13→0.
- err  out  1  level; high while the sampled count is >13.

## Operation
- Input register: count_q <= count every cycle.
- wrap <= (count_q==13 && count==0), registered; high for exactly one cycle.
- err <= (count_q > 13), registered level, not sticky.
- Prescaler pre: counts 0..SCAN_DIV-1. At terminal it returns to 0 and the scan FSM toggles.
- Scan FSM states:
  - S_ONES: an=2'b01. Transitions to S_TENS on prescaler terminal.
  - S_TENS: an=2'b10. Transitions to S_ONES on prescaler terminal.
- Snapshot {bad, tens, ones} loads from count_q only on the S_TENS→S_ONES edge (frame boundary). Load values:
  - bad = (count_q>13).
  - tens = (count_q>=10).
  - ones = count_q − 10·tens.
- seg/an are a combinational decode of registered state and snapshot only; there are no input-to-output paths.
- Digit encoding (gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- bad snapshot: ones shows "E" (7'h79) and tens shows 7'h00.
- Reset values:
  - count_q=0, pre=0, state=S_ONES, snapshot=0.
  - wrap=0, err=0, an=2'b01, seg=7'h3F.

## Timing
- count → count_q: 1 cycle.
- count → wrap/err: wrap is evaluated on the same edge that loads count_q=0. err is set 2 edges after count presents a bad value.
- count → display: visible from the first frame boundary at or after count_q updates. Worst case is 2·SCAN_DIV+1 cycles.
- Digit dwell is exactly SCAN_DIV cycles. A frame is 2·SCAN_DIV cycles.
- Boundary conditions:
  - Reset asserted mid-frame: the next cycle shows reset values regardless of state. Any pending snapshot load is discarded.
  - count changes on the same edge as a frame boundary: the snapshot takes the old count_q. The new value appears one frame later.
  - Consecutive wraps (count held alternating 13/0): wrap pulses on each 13→0 sampled transition only, never on 0→13.
  - Out-of-range value on a frame boundary: bad=1 loads. The next in-range value clears bad at the following boundary.

## Configuration
- LEADING_ZERO_BLANK_EN defined: when tens==0 and bad==0, seg=7'h00 during S_TENS. an[1] still asserts, so scan timing is unchanged.
- LEADING_ZERO_BLANK_EN undefined: tens==0 displays 7'h3F.
- The ones digit is never blanked in either mode.

## Structure
- Package mod14_disp_pkg contains:
  - localparam MOD_MAX=13.
  - the scan state enum {S_ONES, S_TENS}.
  - segment constants SEG_0..SEG_9, SEG_E, SEG_BLANK.
- Sub-module seg7_decode: purely combinational. Inputs are a 4-bit digit and a blank flag; output is seg[6:0]. Digits 10..15 decode to SEG_E.
- Top level holds the input register, wrap/err logic, prescaler, FSM and snapshot.

## Test plan
All scenarios use SCAN_DIV=4.
- Reset held 3 cycles with count=0 → an=01, seg=3F, wrap=0, err=0; the first an toggle occurs 4 cycles after rst deasserts.
- count held at 7 → an alternates 01/10 every 4 cycles; after the first frame boundary ones shows 07 and tens shows 3F (00 with LEADING_ZERO_BLANK_EN).
- count switched 7→12 in mid S_ONES → display stays 7 until the next S_TENS→S_ONES edge, then ones=5B and tens=06.
- count stepped 12,13,0,1 one per cycle → wrap high for exactly one cycle, on the edge loading count_q=0; no other wrap pulses.
- count=15 for 10 cycles, then 3 → err rises 2 edges after 15 is applied; display shows ones=79, tens=00 after the boundary; err falls 2 edges after 3; display shows 4F at the next boundary.
- rst pulsed for one cycle during S_TENS with count=11 → the next cycle shows an=01, seg=3F, pre restarts at 0.
